fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core. It owns PCF and issues requests to instruction memory over a single-outstanding req/gnt/rvalid handshake. It delivers InstrD/PCPlus4D/ValidD to decode and honours StallF/StallD from the hazard unit. Taken branches and jumps resolved in decode redirect it, and it discards wrong-path fetches, including responses still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
StallF  input  1  hazard unit: inhibit issuing a new fetch request.
StallD  input  1  hazard unit: hold the IF/ID register.
PCSrcD  input  1  taken branch in decode.
PCBranchD  input  32  branch target.
JumpD  input  1  jump in decode.
PCJumpD  input  32  jump target.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address (= PCF).
imem_gnt  input  1  memory accepts request this cycle.
imem_rvalid  input  1  response valid.
imem_rdata  input  32  fetched instruction.
InstrD  output  32  IF/ID instruction.
PCPlus4D  output  32  IF/ID PC+4.
ValidD  output  1  IF/ID holds a real instruction (0 = bubble/NOP).

Behaviour:
- Reset (async, rst_n=0): state=FETCH, PCF=RESET_PC, fpc=0, kill=0, buf_valid=0, InstrD=0, PCPlus4D=0, ValidD=0. Imem is on the same reset, so there are no pre-reset responses. Reset mid-transaction abandons everything.
- Redirect event: redir = ValidD & ~StallD & (PCSrcD | JumpD). Target = PCBranchD if PCSrcD, else PCJumpD (PCSrcD has priority).
- Handshake: accepted = imem_req & imem_gnt. Exactly one rvalid follows each accepted request, at least 1 cycle later. Only one request is ever outstanding.
- States FETCH, WAIT, HOLD, DRAIN:
  - FETCH: imem_req = ~StallF & ~redir; imem_addr=PCF. On accept: fpc<=PCF, PCF<=PCF+4, go to WAIT. On redir: PCF<=target, stay in FETCH.
  - WAIT: imem_req=0. When rvalid arrives:
    - redir in the same cycle: drop the data, PCF<=target, go to FETCH.
    - else if ~StallD: load IF/ID (InstrD<=rdata, PCPlus4D<=fpc+4, ValidD<=1), go to FETCH.
    - else: buffer rdata and fpc (buf_valid<=1), go to HOLD.
    - redir without rvalid: PCF<=target, kill<=1, go to DRAIN.
  - HOLD: imem_req=0. When ~StallD and no redir: load IF/ID from the buffer, buf_valid<=0, go to FETCH. When redir: discard the buffer, PCF<=target, go to FETCH.
  - DRAIN: imem_req=0. When rvalid arrives: discard it, kill<=0, go to FETCH. A further redir in DRAIN updates PCF only.
- IF/ID update rule:
  - StallD=1: InstrD/PCPlus4D/ValidD hold.
  - StallD=0 with redir, or with no instruction available: ValidD<=0. InstrD and PCPlus4D hold their values, which are don't-care.
- Latency: accept at cycle t, rvalid at t+k (k≥1), InstrD valid after edge t+k. Peak throughput is 1 instruction per 2 cycles with k=1.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. Targets are used as given; there is no alignment check.
- StallF and StallD asserted together with an rvalid: the data is buffered and nothing is lost.

Test Plan:
1. Reset RESET_PC=0x400, gnt=1, 1-cycle rvalid returning 0x20080005 → imem_addr=0x400 first cycle; InstrD=0x20080005, PCPlus4D=0x404, ValidD=1; next addr 0x404.
2. StallD=1 on the cycle rvalid arrives (rdata 0xAAAA0001) for 3 cycles → state HOLD, IF/ID unchanged. On StallD=0, InstrD=0xAAAA0001 with ValidD=1 and no duplicate or lost instruction.
3. With ValidD=1, PCSrcD=1, PCBranchD=0x1000 while a request is outstanding with 3-cycle latency → ValidD=0 next cycle, the late response is discarded, and the next imem_addr=0x1000.
4. rvalid arrives in the same cycle as JumpD=1 (PCJumpD=0x2000) → response dropped, ValidD=0, next imem_addr=0x2000 the following cycle.
5. StallF=1 in FETCH for 4 cycles → imem_req=0 throughout and PCF unchanged. Once StallF drops, a request issues immediately.
6. PCF=0xFFFF_FFFC accepted → PCPlus4D=0x0000_0000, next imem_addr=0x0. Assert rst_n=0 while in WAIT → all outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage MIPS core.
// Single-outstanding req/gnt/rvalid fetch; decode-resolved redirects discard wrong-path data.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [1:0]  o_dbg_state
);

    // Request handshake: a fetch is accepted in any cycle where imem_req && imem_gnt;
    // exactly one imem_rvalid follows each acceptance, at least one cycle later.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state,     w_state_n;
    logic [31:0] r_pcf,       w_pcf_n;
    logic [31:0] r_fpc,       w_fpc_n;
    logic        r_kill,      w_kill_n;
    logic        r_buf_valid, w_buf_valid_n;
    logic [31:0] r_buf_instr, w_buf_instr_n;
    logic [31:0] r_buf_pc,    w_buf_pc_n;
    logic [31:0] r_instr_d,   w_instr_n;
    logic [31:0] r_pcplus4_d, w_pcplus4_n;
    logic        r_valid_d,   w_valid_n;

    logic        w_redir;
    logic [31:0] w_target;

    // The redirecting instruction itself must be leaving decode for the redirect to count.
    assign w_redir  = r_valid_d & ~StallD & (PCSrcD | JumpD);
    assign w_target = PCSrcD ? PCBranchD : PCJumpD;

    always_comb begin
        w_state_n     = r_state;
        w_pcf_n       = r_pcf;
        w_fpc_n       = r_fpc;
        w_kill_n      = r_kill;
        w_buf_valid_n = r_buf_valid;
        w_buf_instr_n = r_buf_instr;
        w_buf_pc_n    = r_buf_pc;
        w_instr_n     = r_instr_d;
        w_pcplus4_n   = r_pcplus4_d;
        w_valid_n     = StallD ? r_valid_d : 1'b0;
        imem_req      = 1'b0;

        case (r_state)
            S_FETCH: begin
                imem_req = ~StallF & ~w_redir;
                if (w_redir) begin
                    w_pcf_n = w_target;
                end else if (imem_req && imem_gnt) begin
                    w_fpc_n   = r_pcf;
                    w_pcf_n   = r_pcf + 32'd4;
                    w_state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_n = S_FETCH;
                    if (w_redir) begin
                        w_pcf_n = w_target;
                    end else if (!StallD) begin
                        w_instr_n   = imem_rdata;
                        w_pcplus4_n = r_fpc + 32'd4;
                        w_valid_n   = 1'b1;
                    end else begin
                        w_buf_instr_n = imem_rdata;
                        w_buf_pc_n    = r_fpc;
                        w_buf_valid_n = 1'b1;
                        w_state_n     = S_HOLD;
                    end
                end else if (w_redir) begin
                    w_pcf_n   = w_target;
                    w_kill_n  = 1'b1;
                    w_state_n = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (w_redir) begin
                    w_buf_valid_n = 1'b0;
                    w_pcf_n       = w_target;
                    w_state_n     = S_FETCH;
                end else if (!StallD && r_buf_valid) begin
                    w_instr_n     = r_buf_instr;
                    w_pcplus4_n   = r_buf_pc + 32'd4;
                    w_valid_n     = 1'b1;
                    w_buf_valid_n = 1'b0;
                    w_state_n     = S_FETCH;
                end
            end
            S_DRAIN: begin
                // The wrong-path response is swallowed; later redirects only move PCF.
                if (w_redir) begin
                    w_pcf_n = w_target;
                end
                if (imem_rvalid && r_kill) begin
                    w_kill_n  = 1'b0;
                    w_state_n = S_FETCH;
                end
            end
            default: begin
                w_state_n = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_pcf       <= RESET_PC;
            r_fpc       <= 32'd0;
            r_kill      <= 1'b0;
            r_buf_valid <= 1'b0;
            r_buf_instr <= 32'd0;
            r_buf_pc    <= 32'd0;
            r_instr_d   <= 32'd0;
            r_pcplus4_d <= 32'd0;
            r_valid_d   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_pcf       <= w_pcf_n;
            r_fpc       <= w_fpc_n;
            r_kill      <= w_kill_n;
            r_buf_valid <= w_buf_valid_n;
            r_buf_instr <= w_buf_instr_n;
            r_buf_pc    <= w_buf_pc_n;
            r_instr_d   <= w_instr_n;
            r_pcplus4_d <= w_pcplus4_n;
            r_valid_d   <= w_valid_n;
        end
    end

    assign imem_addr   = r_pcf;
    assign InstrD      = r_instr_d;
    assign PCPlus4D    = r_pcplus4_d;
    assign ValidD      = r_valid_d;
    assign o_dbg_state = r_state;

endmodule
